// File: rtl/bus_bridge_pkg.sv
// Shared types and widths for the external bus bridge.
package bus_bridge_pkg;

    localparam int PHASE_W   = 4;
    localparam int RST_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_RSTWAIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/irq_sync_latch.sv
// Device interrupt synchroniser with either level pass-through or
// rising-edge pending latch cleared by an acknowledge pulse.
module irq_sync_latch #(
    parameter int IRQ_EDGE = 0
) (
    input  logic clk_bus,
    input  logic rst,
    input  logic dev_int,
    input  logic irq_ack,
    output logic irq
);

    logic sync1, irq_s, irq_s_d, irq_q;

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            irq_s   <= 1'b0;
            irq_s_d <= 1'b0;
        end else begin
            sync1   <= dev_int;
            irq_s   <= sync1;
            irq_s_d <= irq_s;
        end
    end

    generate
        if (IRQ_EDGE != 0) begin : g_edge
            // A new edge takes priority over a simultaneous acknowledge.
            always_ff @(posedge clk_bus or posedge rst) begin
                if (rst)
                    irq_q <= 1'b0;
                else if (irq_s && !irq_s_d)
                    irq_q <= 1'b1;
                else if (irq_ack)
                    irq_q <= 1'b0;
            end
        end else begin : g_level
            logic unused_level;
            assign unused_level = irq_ack | irq_s_d;

            always_ff @(posedge clk_bus or posedge rst) begin
                if (rst)
                    irq_q <= 1'b0;
                else
                    irq_q <= irq_s;
            end
        end
    endgenerate

    assign irq = irq_q;

endmodule

// File: rtl/ext_bus_bridge.sv
// Bridge from the internal CPU bus to an asynchronous parallel peripheral
// with programmable setup/strobe/hold timing and a timed device reset.
module ext_bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int DEV_DATA_W = 16,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1,
    parameter int RST_CYC    = 16,
    parameter int IRQ_EDGE   = 0
) (
    input  logic                  clk_bus,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     bus_address,
    input  logic [31:0]           bus_data_i,
    output logic [31:0]           bus_data_o,
    input  logic                  bus_read,
    input  logic                  bus_write,
    output logic                  bus_stall,
    output logic                  bus_irq,
    input  logic                  irq_ack,
    output logic [ADDR_W-1:0]     dev_address,
    inout  wire  [DEV_DATA_W-1:0] dev_data,
    output logic                  dev_we_n,
    output logic                  dev_oe_n,
    output logic                  dev_ce_n,
    output logic                  dev_rst_n,
    input  logic                  dev_int
);

    generate
        if (DEV_DATA_W != 8 && DEV_DATA_W != 16) begin : g_bad_width
            $error("ext_bus_bridge: DEV_DATA_W must be 8 or 16");
        end
        if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
            HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_timing
            $error("ext_bus_bridge: SETUP/STROBE/HOLD_CYC must be 1..15");
        end
        if (RST_CYC < 1 || RST_CYC > 255) begin : g_bad_rst
            $error("ext_bus_bridge: RST_CYC must be 1..255");
        end
        if (IRQ_EDGE != 0 && IRQ_EDGE != 1) begin : g_bad_irq
            $error("ext_bus_bridge: IRQ_EDGE must be 0 or 1");
        end
        if (ADDR_W < 1) begin : g_bad_addr
            $error("ext_bus_bridge: ADDR_W must be at least 1");
        end
    endgenerate

    // Phase counter holds remaining cycles minus one for the current state.
    localparam logic [PHASE_W-1:0]   SETUP_LD  = PHASE_W'(SETUP_CYC - 1);
    localparam logic [PHASE_W-1:0]   STROBE_LD = PHASE_W'(STROBE_CYC - 1);
    localparam logic [PHASE_W-1:0]   HOLD_LD   = PHASE_W'(HOLD_CYC - 1);
    localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(RST_CYC - 1);

    state_e                 state, state_nx;
    logic [PHASE_W-1:0]     phase_cnt, phase_nx;
    logic [RST_CNT_W-1:0]   rst_cnt;
    logic [ADDR_W-1:0]      addr_q;
    logic [DEV_DATA_W-1:0]  wdata_q, rdata_q;
    logic                   is_wr_q;
    logic                   drive;
    logic                   phase_last;
    logic                   bus_req;
    logic                   unused_data_hi;

    assign phase_last     = (phase_cnt == '0);
    assign bus_req        = bus_read | bus_write;
    assign unused_data_hi = ^bus_data_i[31:DEV_DATA_W];

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            state     <= ST_RSTWAIT;
            phase_cnt <= '0;
        end else begin
            state     <= state_nx;
            phase_cnt <= phase_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase_cnt;
        case (state)
            ST_RSTWAIT: begin
                if (rst_cnt == RST_LAST) begin
                    state_nx = ST_IDLE;
                    phase_nx = '0;
                end
            end
            ST_IDLE: begin
                if (bus_req) begin
                    state_nx = ST_SETUP;
                    phase_nx = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (phase_last) begin
                    state_nx = ST_STROBE;
                    phase_nx = STROBE_LD;
                end else begin
                    phase_nx = phase_cnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (phase_last) begin
                    state_nx = ST_HOLD;
                    phase_nx = HOLD_LD;
                end else begin
                    phase_nx = phase_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (phase_last) begin
                    state_nx = ST_DONE;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                phase_nx = '0;
            end
            default: begin
                state_nx = ST_RSTWAIT;
                phase_nx = '0;
            end
        endcase
    end

    always_comb begin
        dev_ce_n  = 1'b1;
        dev_we_n  = 1'b1;
        dev_oe_n  = 1'b1;
        dev_rst_n = 1'b1;
        drive     = 1'b0;
        case (state)
            ST_RSTWAIT: dev_rst_n = 1'b0;
            ST_SETUP: begin
                dev_ce_n = 1'b0;
                drive    = is_wr_q;
            end
            ST_STROBE: begin
                dev_ce_n = 1'b0;
                dev_we_n = !is_wr_q;
                dev_oe_n = is_wr_q;
                drive    = is_wr_q;
            end
            ST_HOLD: begin
                dev_ce_n = 1'b0;
                drive    = is_wr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst)
            rst_cnt <= '0;
        else if (state == ST_RSTWAIT)
            rst_cnt <= rst_cnt + 1'b1;
    end

    // Write wins when both requests are presented together.
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state == ST_IDLE && bus_req) begin
                addr_q  <= bus_address;
                wdata_q <= bus_data_i[DEV_DATA_W-1:0];
                is_wr_q <= bus_write;
            end
            if (state == ST_STROBE && phase_last && !is_wr_q)
                rdata_q <= dev_data;
        end
    end

    assign dev_data    = drive ? wdata_q : {DEV_DATA_W{1'bz}};
    assign dev_address = addr_q;
    assign bus_data_o  = {{(32-DEV_DATA_W){1'b0}}, rdata_q};
    assign bus_stall   = bus_req & (state != ST_DONE);

    irq_sync_latch #(
        .IRQ_EDGE(IRQ_EDGE)
    ) u_irq (
        .clk_bus (clk_bus),
        .rst     (rst),
        .dev_int (dev_int),
        .irq_ack (irq_ack),
        .irq     (bus_irq)
    );

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Two bridges (16-bit edge-irq with 1/2/1 timing, 8-bit level-irq with 1/1/1
// timing) driven by random accesses against a pin-level device model.
module tb_ext_bus_bridge;

    localparam int A_S = 1, A_ST = 2, A_H = 1, A_RST = 16, B_RST = 4;
    localparam logic [15:0] KEEP16 = 16'hC3C3;
    localparam logic [7:0]  KEEP8  = 8'h3C;

    logic clk_bus = 1'b0;
    logic rst = 1'b1;
    always #5 clk_bus = ~clk_bus;

    logic [2:0]        bus_address;
    logic [31:0]       bus_data_i;
    logic [1:0]        rd_req, wr_req;
    logic              irq_ack, dev_int;
    logic [1:0][31:0]  dout;
    logic [1:0][2:0]   daddr;
    logic [1:0]        stall, irq, we_n, oe_n, ce_n, drst_n;
    wire  [15:0]       dd16;
    wire  [7:0]        dd8;

    logic [15:0] mem0 [8] = '{default: '0};
    logic [7:0]  mem1 [8] = '{default: '0};
    logic [31:0] exp_mem [2][8];
    logic [31:0] last_rd [2];

    int vectors = 0;
    int miscompares = 0;

    ext_bus_bridge #(
        .ADDR_W(3), .DEV_DATA_W(16), .SETUP_CYC(A_S), .STROBE_CYC(A_ST),
        .HOLD_CYC(A_H), .RST_CYC(A_RST), .IRQ_EDGE(1)
    ) u_dut_a (
        .clk_bus(clk_bus), .rst(rst), .bus_address(bus_address),
        .bus_data_i(bus_data_i), .bus_data_o(dout[0]), .bus_read(rd_req[0]),
        .bus_write(wr_req[0]), .bus_stall(stall[0]), .bus_irq(irq[0]),
        .irq_ack(irq_ack), .dev_address(daddr[0]), .dev_data(dd16),
        .dev_we_n(we_n[0]), .dev_oe_n(oe_n[0]), .dev_ce_n(ce_n[0]),
        .dev_rst_n(drst_n[0]), .dev_int(dev_int)
    );

    ext_bus_bridge #(
        .ADDR_W(3), .DEV_DATA_W(8), .SETUP_CYC(1), .STROBE_CYC(1),
        .HOLD_CYC(1), .RST_CYC(B_RST), .IRQ_EDGE(0)
    ) u_dut_b (
        .clk_bus(clk_bus), .rst(rst), .bus_address(bus_address),
        .bus_data_i(bus_data_i), .bus_data_o(dout[1]), .bus_read(rd_req[1]),
        .bus_write(wr_req[1]), .bus_stall(stall[1]), .bus_irq(irq[1]),
        .irq_ack(irq_ack), .dev_address(daddr[1]), .dev_data(dd8),
        .dev_we_n(we_n[1]), .dev_oe_n(oe_n[1]), .dev_ce_n(ce_n[1]),
        .dev_rst_n(drst_n[1]), .dev_int(dev_int)
    );

    // Device model: answers reads while OE is low, keeps a known pattern on
    // the pins while CE is high so a bridge that fails to release shows up.
    assign dd16 = ce_n[0] ? KEEP16 : (!oe_n[0] ? mem0[daddr[0]] : 16'hzzzz);
    assign dd8  = ce_n[1] ? KEEP8  : (!oe_n[1] ? mem1[daddr[1]] : 8'hzz);

    always @(negedge clk_bus) begin
        if (!ce_n[0] && !we_n[0]) mem0[daddr[0]] <= dd16;
        if (!ce_n[1] && !we_n[1]) mem1[daddr[1]] <= dd8;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pins(input int u);
        return (u == 0) ? {16'h0, dd16} : {24'h0, dd8};
    endfunction

    function automatic logic [31:0] keep_of(input int u);
        return (u == 0) ? {16'h0, KEEP16} : {24'h0, KEEP8};
    endfunction

    function automatic logic [31:0] mem_of(input int u, input logic [2:0] a);
        return (u == 0) ? {16'h0, mem0[a]} : {24'h0, mem1[a]};
    endfunction

    // One bus access; counts pin activity cycles and checks the result.
    task automatic access(input int u, input bit wr, input logic [2:0] ad,
                          input logic [31:0] d, input bit drop);
        int lat, cec, stc, st_first, exp_lat, exp_st;
        logic [31:0] mask;
        bit done;
        exp_st  = (u == 0) ? A_ST : 1;
        exp_lat = (u == 0) ? A_S + A_ST + A_H + 2 : 5;
        mask    = (u == 0) ? 32'h0000_FFFF : 32'h0000_00FF;
        lat = 0; cec = 0; stc = 0; st_first = 0; done = 1'b0;
        @(posedge clk_bus); #1;
        bus_address = ad;
        bus_data_i  = d;
        wr_req[u]   = wr;
        rd_req[u]   = !wr;
        while (!done && lat < 64) begin
            #1;
            lat++;
            if (!ce_n[u]) cec++;
            if (!(wr ? we_n[u] : oe_n[u])) begin
                stc++;
                if (st_first == 0) st_first = cec;
            end
            done = drop ? (cec > 0 && ce_n[u]) : !stall[u];
            if (!done) begin
                @(posedge clk_bus); #1;
                if (drop) begin
                    wr_req[u] = 1'b0;
                    rd_req[u] = 1'b0;
                end
            end
        end
        chk("latency", lat, exp_lat);
        chk("ce_cycles", cec, exp_lat - 2);
        chk("strobe_cycles", stc, exp_st);
        chk("strobe_pos", st_first, 2);
        chk("done_release", pins(u), keep_of(u));
        if (wr) begin
            exp_mem[u][ad] = d & mask;
            chk("dev_mem", mem_of(u, ad), exp_mem[u][ad]);
            chk("rd_persist", dout[u], last_rd[u]);
        end else begin
            chk("read_data", dout[u], exp_mem[u][ad]);
            last_rd[u] = exp_mem[u][ad];
        end
        wr_req[u] = 1'b0;
        rd_req[u] = 1'b0;
    endtask

    int  n;
    bit  stall_hi;

    initial begin
        rd_req = '0; wr_req = '0; bus_address = '0; bus_data_i = '0;
        irq_ack = 1'b0; dev_int = 1'b0;
        for (int a = 0; a < 8; a++) begin
            exp_mem[0][a] = '0;
            exp_mem[1][a] = '0;
        end
        last_rd[0] = '0;
        last_rd[1] = '0;

        repeat (3) @(posedge clk_bus);
        #1;
        chk("rst_ce_n", {30'h0, ce_n}, 32'h3);
        chk("rst_we_n", {30'h0, we_n}, 32'h3);
        chk("rst_oe_n", {30'h0, oe_n}, 32'h3);
        chk("rst_dev_rst_n", {30'h0, drst_n}, 32'h0);
        chk("rst_irq", {30'h0, irq}, 32'h0);
        chk("rst_dout_a", dout[0], 32'h0);
        chk("rst_dout_b", dout[1], 32'h0);
        chk("rst_daddr", {26'h0, daddr[1], daddr[0]}, 32'h0);
        chk("rst_pins_a", pins(0), keep_of(0));
        chk("rst_pins_b", pins(1), keep_of(1));

        // Write held from before reset release.
        bus_address = 3'd7;
        bus_data_i  = 32'h0000_5EED;
        wr_req[0]   = 1'b1;
        rst = 1'b0;
        n = 0;
        stall_hi = 1'b1;
        #1;
        while (!drst_n[0] && n < 100) begin
            n++;
            if (!stall[0]) stall_hi = 1'b0;
            @(posedge clk_bus); #2;
        end
        chk("rstwait_cycles", n, A_RST);
        chk("rstwait_stall", {31'h0, stall_hi}, 32'h1);
        chk("idle_ce_n", {31'h0, ce_n[0]}, 32'h1);
        @(posedge clk_bus); #2;
        chk("first_setup_ce_n", {31'h0, ce_n[0]}, 32'h0);
        n = 0;
        while (stall[0] && n < 100) begin
            n++;
            @(posedge clk_bus); #2;
        end
        wr_req[0] = 1'b0;
        exp_mem[0][7] = 32'h0000_5EED;
        chk("held_write_mem", mem_of(0, 3'd7), exp_mem[0][7]);
        chk("b_out_of_reset", {31'h0, drst_n[1]}, 32'h1);

        // Directed accesses.
        access(0, 1'b1, 3'd3, 32'h0000_ABCD, 1'b0);
        access(0, 1'b1, 3'd5, 32'h0000_1234, 1'b0);
        access(0, 1'b0, 3'd5, 32'h0, 1'b0);
        access(0, 1'b1, 3'd1, 32'hDEAD_0042, 1'b0);
        chk("read_persist_1234", dout[0], 32'h0000_1234);
        access(1, 1'b1, 3'd2, 32'hFFFF_FF5A, 1'b0);
        chk("b_pins_5a", mem_of(1, 3'd2), 32'h0000_005A);
        access(1, 1'b1, 3'd6, 32'h0000_00A5, 1'b0);
        access(1, 1'b0, 3'd6, 32'h0, 1'b0);
        chk("b_read_a5", dout[1], 32'h0000_00A5);

        // Random accesses, occasionally dropping the request mid-access.
        repeat (80) begin
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 7) == 0));
        end

        // Interrupts: A latches edges, B follows the level.
        @(posedge clk_bus); #1;
        dev_int = 1'b1;
        n = 0;
        while (!irq[0] && n < 10) begin
            @(posedge clk_bus); #1;
            n++;
        end
        chk("irq_latency_ok", {31'h0, (n >= 2 && n <= 3)}, 32'h1);
        chk("irq_level_high", {31'h0, irq[1]}, 32'h1);
        dev_int = 1'b0;
        repeat (4) begin @(posedge clk_bus); #1; end
        chk("irq_pending", {31'h0, irq[0]}, 32'h1);
        chk("irq_level_low", {31'h0, irq[1]}, 32'h0);
        irq_ack = 1'b1;
        @(posedge clk_bus); #1;
        irq_ack = 1'b0;
        chk("irq_ack_clears", {31'h0, irq[0]}, 32'h0);
        dev_int = 1'b1;
        repeat (3) begin @(posedge clk_bus); #1; end
        chk("irq_second_edge", {31'h0, irq[0]}, 32'h1);
        dev_int = 1'b0;
        repeat (4) begin @(posedge clk_bus); #1; end
        dev_int = 1'b1;
        repeat (2) begin @(posedge clk_bus); #1; end
        irq_ack = 1'b1;
        @(posedge clk_bus); #1;
        irq_ack = 1'b0;
        chk("irq_set_beats_ack", {31'h0, irq[0]}, 32'h1);
        dev_int = 1'b0;
        irq_ack = 1'b1;
        @(posedge clk_bus); #1;
        irq_ack = 1'b0;
        chk("irq_ack_alone", {31'h0, irq[0]}, 32'h0);

        // Reset in the middle of a write strobe.
        @(posedge clk_bus); #1;
        bus_address = 3'd4;
        bus_data_i  = 32'h0000_7777;
        wr_req[0]   = 1'b1;
        n = 0;
        while (we_n[0] && n < 20) begin
            @(posedge clk_bus); #1;
            n++;
        end
        chk("strobe_reached", {31'h0, we_n[0]}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_we_n", {31'h0, we_n[0]}, 32'h1);
        chk("midrst_ce_n", {31'h0, ce_n[0]}, 32'h1);
        chk("midrst_pins", pins(0), keep_of(0));
        chk("midrst_dev_rst_n", {31'h0, drst_n[0]}, 32'h0);
        wr_req[0] = 1'b0;
        repeat (2) @(posedge clk_bus);
        #1;
        rst = 1'b0;
        n = 0;
        #1;
        while (!drst_n[0] && n < 100) begin
            n++;
            @(posedge clk_bus); #2;
        end
        chk("restart_rstwait", n, A_RST);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ext_bus_bridge.md
Name: ext_bus_bridge

Overview:
Parametrised bridge from the internal single-master CPU bus to an external asynchronous parallel peripheral, such as an Ethernet MAC, a UART or a CPLD. It adds the following to the fixed-timing bridge generation:
- configurable device data width and address width
- programmable setup/strobe/hold timing
- a timed device-reset sequencer
- an interrupt synchroniser with level or edge/pending mode.

It sits between the system bus decoder and board pins; one instance per external chip.

Parameters:
ADDR_W, 3, width of bus_address and dev_address
DEV_DATA_W, 16, external data width; legal values 8 or 16
SETUP_CYC, 1, cycles of CE asserted before strobe (1..15)
STROBE_CYC, 1, cycles WE_n/OE_n asserted (1..15)
HOLD_CYC, 1, cycles of CE held after strobe (1..15)
RST_CYC, 16, cycles dev_rst_n is held low after rst deasserts (1..255)
IRQ_EDGE, 0, 0 = level pass-through; 1 = rising-edge latched pending

Ports:
clk_bus  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
bus_address  in  ADDR_W  word address from the bus decoder
bus_data_i  in  32  write data; low DEV_DATA_W bits are used
bus_data_o  out  32  read data; bits above DEV_DATA_W are always 0
bus_read  in  1  read request, held until stall is low
bus_write  in  1  write request, held until stall is low
bus_stall  out  1  high while the request is not yet complete
bus_irq  out  1  interrupt to the CPU
irq_ack  in  1  one-cycle pulse that clears the pending interrupt (edge mode only)
dev_address  out  ADDR_W  device address pins
dev_data  inout  DEV_DATA_W  device data pins, tristated when not writing
dev_we_n  out  1  write strobe, active low
dev_oe_n  out  1  read strobe, active low
dev_ce_n  out  1  chip enable, active low
dev_rst_n  out  1  device reset, active low
dev_int  in  1  asynchronous device interrupt, active high

Behaviour:
- Reset values:
  - dev_ce_n = dev_we_n = dev_oe_n = 1; dev_rst_n = 0; dev_address = 0; dev_data = Z
  - bus_data_o = 0; bus_irq = 0; FSM in RSTWAIT; rst_cnt = 0.
- Assertion of rst forces all of the above immediately, including mid-access: strobes go inactive and dev_data is released the same instant.
- FSM states: RSTWAIT, IDLE, SETUP, STROBE, HOLD, DONE. A single phase counter is reloaded on every state entry.
- RSTWAIT:
  - dev_rst_n = 0 for RST_CYC cycles after rst falls, then dev_rst_n = 1 and go to IDLE.
  - Any request in this state is stalled.
- IDLE:
  - On bus_read or bus_write, latch address, direction and write data, then go to SETUP.
  - If both requests are high, the write wins.
- SETUP: dev_ce_n = 0; dev_data is driven on writes; lasts SETUP_CYC cycles.
- STROBE:
  - dev_ce_n = 0; dev_we_n = 0 (write) or dev_oe_n = 0 (read); lasts STROBE_CYC cycles.
  - Read data is sampled into bus_data_o on the last STROBE cycle and zero-extended.
- HOLD: dev_ce_n = 0; strobes = 1; write data is still driven; lasts HOLD_CYC cycles.
- DONE:
  - All device signals are inactive and dev_data = Z; bus_stall = 0 for exactly this one cycle.
  - Then go to IDLE. A request still held in IDLE starts a new access.
- bus_stall = (bus_read | bus_write) & (state != DONE). This is combinational and low when idle with no request.
- Access latency: SETUP_CYC + STROBE_CYC + HOLD_CYC + 2 cycles from request to stall low, counting the IDLE capture cycle.
- The bus must not change address or data while stall is high. If the master drops the request mid-access, the access still completes with no abort.
- bus_data_o holds the last read value until the next read completes.
- IRQ:
  - dev_int passes through a 2-flop synchroniser to produce irq_s.
  - IRQ_EDGE = 0: bus_irq = irq_s, registered.
  - IRQ_EDGE = 1: a pending bit is set on the rising edge of irq_s and cleared by irq_ack; bus_irq = pending.
  - If irq_ack and a new edge coincide, set wins.
  - The IRQ logic runs during RSTWAIT.
- Width rule: DEV_DATA_W = 8 uses bus_data_i[7:0] only. Illegal parameter values must stop elaboration through a generate-time error.

Decomposition:
- Shared package bus_bridge_pkg holds:
  - the FSM state enum
  - a phase-counter width constant of 4 bits
  - the reset-counter width of 8 bits.
- One natural sub-module, irq_sync_latch, contains the synchroniser, edge detect and pending/ack logic, parametrised by IRQ_EDGE.
- The FSM and tristate control stay in the top module.

Test Plan:
- Reset release with RST_CYC = 16, bus_write held from cycle 0: dev_rst_n is 0 for exactly 16 cycles, bus_stall stays 1 throughout, and the write starts on the cycle after dev_rst_n rises.
- Write, addr 3, data 0x0000ABCD, SETUP = 1, STROBE = 2, HOLD = 1:
  - dev_ce_n low for 4 cycles; dev_we_n low for cycles 2–3 of those 4
  - dev_data = 0xABCD while CE is low, Z in DONE
  - stall low on cycle 6.
- Read with the device driving 0x1234, default timing: bus_data_o = 0x00001234 in the DONE cycle; the value persists after the access.
- DEV_DATA_W = 8, write 0xFFFFFF5A then read with the device driving 0xA5: pins carry 0x5A; bus_data_o = 0x000000A5.
- IRQ_EDGE = 1:
  - a dev_int pulse raises bus_irq 2–3 cycles later
  - irq_ack drops it next cycle
  - a second edge arriving in the same cycle as irq_ack keeps bus_irq = 1.
- Assert rst during a write STROBE: dev_we_n, dev_ce_n = 1 and dev_data = Z immediately; dev_rst_n = 0; the FSM restarts in RSTWAIT.
